mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator-side controller for the 32-bit byte-banked data memory (Memoria32). Accepts one load or store request at a time from the CPU datapath and sequences the memory's `raddress`/`waddress`/`Datain`/`Wr` ports. Handles byte, half, word and doubleword accesses: sign/zero extension on loads, read-modify-write on sub-word stores, and two-beat transfers for doublewords. It sits between the CPU's memory stage and the data memory instance.

## Interface
- `ADDR_W`, 64, request and memory address width
- `Clk`  in  1  clock; all state changes on its rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present; must be held until accepted
- `req_ready`  out  1  high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 doubleword
- `req_unsigned`  in  1  loads only: zero-extend (1) or sign-extend (0)
- `req_addr`  in  ADDR_W  byte address; no alignment restriction
- `req_wdata`  in  64  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse for loads and stores
- `resp_rdata`  out  64  extended load data; holds until the next load completes
- `raddress`  out  ADDR_W  memory read address
- `waddress`  out  ADDR_W  memory write address
- `Datain`  out  32  memory write data
- `Dataout`  in  32  memory read data, valid the cycle after `raddress` is sampled
- `Wr`  out  1  memory write enable

## Operation
- Handshake: a request is accepted at the rising edge where `req_valid && req_ready`. The unit latches addr A, size, we, unsigned and wdata at that edge. `req_valid` while busy is ignored.
- States: IDLE, RADDR, RDATA, RDATA_HI, WRITE, WRITE_HI, DONE.
- Load B/H/W: IDLE → RADDR → RDATA → DONE.
  - RADDR drives `raddress`=A.
  - RDATA captures `Dataout`.
- Load D: IDLE → RADDR → RDATA → RDATA_HI → DONE.
  - RDATA captures the low word and drives `raddress`=A+4.
  - RDATA_HI captures the high word.
- Store W: IDLE → WRITE → DONE.
- Store D: IDLE → WRITE → WRITE_HI → DONE.
  - WRITE writes A with wdata[31:0].
  - WRITE_HI writes A+4 with wdata[63:32].
- Store B/H: IDLE → RADDR → RDATA → WRITE → DONE (read-modify-write).
  - In WRITE, `Datain` = {rd[31:8], wdata[7:0]} for B, or {rd[31:16], wdata[15:0]} for H.
- `Wr`=1 only in WRITE and WRITE_HI. `waddress`/`Datain` are meaningful only there.
- Lane mapping: the byte at A is `Dataout[7:0]`; a half is [15:0]; a word is [31:0]; for D, the low word is at A and the high word at A+4.
- Load extension is to 64 bits:
  - B/H/W sign-extend bit 7/15/31 unless `req_unsigned`.
  - D is not extended; `req_unsigned` is ignored for D.
- A+4 is computed modulo 2^ADDR_W and wraps silently.
- DONE: `resp_valid`=1 and `req_ready`=0, then go to IDLE. The earliest next acceptance is the cycle after DONE.

## Timing
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `raddress`=0; `waddress`=0; `Datain`=0; `Wr`=0.
- Latency, counted from the accept edge to the `resp_valid` cycle:
  - load B/H/W: 3 cycles
  - load D: 4 cycles
  - store W: 2 cycles
  - store D: 3 cycles
  - store B/H: 4 cycles
- `Wr` is registered-state decoded. Back-to-back writes occur only in the WRITE → WRITE_HI sequence.
- Reset mid-operation: everything returns to reset values immediately, including `Wr` (asynchronous). No `resp_valid` is issued.
  - A doubleword store interrupted in WRITE_HI keeps its low word written.
  - A sub-word RMW interrupted before WRITE leaves memory unchanged.
- `resp_rdata` updates only at the edge entering DONE for loads. Stores do not alter it.

## Structure
- Shared package `mem_access_pkg` contains:
  - `size_t` enum (BYTE, HALF, WORD, DWORD)
  - `state_t` enum (the seven states)
  - constant `WORD_BYTES`=4
- One sub-module is natural: `mem_lane_align`, combinational. It provides load extension (word, size, unsigned → 64-bit) and store merge (read word, wdata, size → `Datain`).
- The FSM, address/data registers and handshake live in `mem_access_unit`.

## Test plan
- Preload bytes 0x100..0x103 = 80,7F,01,FF:
  - LB → `resp_rdata`=0xFFFF_FFFF_FFFF_FF80, with `resp_valid` 3 cycles after accept.
  - LBU → 0x80.
  - LH → 0x7F80.
  - LW → 0xFFFF_FFFF_FF01_7F80.
  - LWU → 0x0000_0000_FF01_7F80.
- SD 0x1122_3344_5566_7788 at 0x200:
  - `Wr` is high exactly 2 cycles, with `waddress` 0x200 then 0x204 and `Datain` 0x5566_7788 then 0x1122_3344.
  - A following LD 0x200 returns the same value.
- SB 0xAB at 0x100 with the preload above:
  - a read of 0x100 comes first;
  - then a single `Wr` cycle with `Datain`=0xFF01_7FAB;
  - then LW returns 0xFFFF_FFFF_FF01_7FAB.
- Assert `Reset_n`=0 mid-cycle during WRITE_HI of an SD:
  - `Wr` drops before the next edge; `req_ready`=1; no `resp_valid`;
  - only the low word is changed in memory.
- Hold `req_valid` with a second request while busy:
  - it is not accepted until the cycle after DONE;
  - exactly one `resp_valid` per accepted request.
- LD at 0xFFFF_FFFF_FFFF_FFFE: `raddress` goes 0x…FFFE then 0x0000_0000_0000_0002, and the result is assembled low/high correctly.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the data-memory access unit
package mem_access_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} size_t;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, RDATA_HI, WRITE, WRITE_HI, DONE} state_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: load sign/zero extension and sub-word store merge
module mem_lane_align import mem_access_pkg::*; (
  input  logic [31:0] rdWord,
  input  size_t       size,
  input  logic        isUnsigned,
  input  logic [31:0] wdata,
  output logic [63:0] loadExt,
  output logic [31:0] storeMerge
);
  always_comb begin
    loadExt = size == BYTE ? {{56{~isUnsigned & rdWord[7]}}, rdWord[7:0]}
            : size == HALF ? {{48{~isUnsigned & rdWord[15]}}, rdWord[15:0]}
            : {{32{~isUnsigned & rdWord[31] & (size == WORD)}}, rdWord};
    storeMerge = size == BYTE ? {rdWord[31:8], wdata[7:0]}
               : size == HALF ? {rdWord[31:16], wdata[15:0]}
               : wdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences Memoria32 read/write ports for B/H/W/D loads and stores
module mem_access_unit import mem_access_pkg::*; #(
  parameter int ADDR_W = 64
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic [ADDR_W-1:0] raddress,
  output logic [ADDR_W-1:0] waddress,
  output logic [31:0]       Datain,
  input  logic [31:0]       Dataout,
  output logic              Wr
);
  state_t            state;
  size_t             sizeQ;
  logic              weQ;
  logic              unsignedQ;
  logic [ADDR_W-1:0] addrQ;
  logic [63:0]       wdataQ;
  logic [31:0]       loWord;
  logic [63:0]       loadExt;
  logic [31:0]       storeMerge;
  logic [ADDR_W-1:0] addrHi;

  assign addrHi = addrQ + ADDR_W'(WORD_BYTES);

  mem_lane_align align (
    .rdWord(Dataout),
    .size(sizeQ),
    .isUnsigned(unsignedQ),
    .wdata(wdataQ[31:0]),
    .loadExt(loadExt),
    .storeMerge(storeMerge)
  );

  // Outputs are registered alongside the state so each is valid for the whole state cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      sizeQ      <= BYTE;
      weQ        <= 1'b0;
      unsignedQ  <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      loWord     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      raddress   <= '0;
      waddress   <= '0;
      Datain     <= '0;
      Wr         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      Wr         <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addrQ     <= req_addr;
          sizeQ     <= size_t'(req_size);
          weQ       <= req_we;
          unsignedQ <= req_unsigned;
          wdataQ    <= req_wdata;
          req_ready <= 1'b0;
          if (req_we && req_size[1]) begin
            state    <= WRITE;
            Wr       <= 1'b1;
            waddress <= req_addr;
            Datain   <= req_wdata[31:0];
          end else begin
            state    <= RADDR;
            raddress <= req_addr;
          end
        end
        RADDR: begin
          state <= RDATA;
          // Memory samples the next address one cycle ahead of its data
          if (!weQ && sizeQ == DWORD) raddress <= addrHi;
        end
        RDATA: if (weQ) begin
          state    <= WRITE;
          Wr       <= 1'b1;
          waddress <= addrQ;
          Datain   <= storeMerge;
        end else if (sizeQ == DWORD) begin
          state  <= RDATA_HI;
          loWord <= Dataout;
        end else begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_rdata <= loadExt;
        end
        RDATA_HI: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_rdata <= {Dataout, loWord};
        end
        WRITE: if (sizeQ == DWORD) begin
          state    <= WRITE_HI;
          Wr       <= 1'b1;
          waddress <= addrHi;
          Datain   <= wdataQ[63:32];
        end else begin
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        WRITE_HI: begin
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized checks against a byte-level memory reference
module tb_mem_access_unit;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, Wr;
  logic [63:0] resp_rdata, raddress, waddress;
  logic [31:0] Datain, Dataout;

  int total = 0;
  int passed = 0;
  int respCount = 0;
  logic [7:0]  simMem [logic [63:0]];
  logic [7:0]  refMem [logic [63:0]];
  logic [63:0] wrAddrLog [$];
  logic [31:0] wrDataLog [$];
  logic [63:0] lastLoad = '0;
  logic [63:0] ra1, ra2;
  logic [31:0] rdWord;

  always #5 Clk = ~Clk;

  mem_access_unit #(.ADDR_W(64)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .raddress(raddress), .waddress(waddress), .Datain(Datain),
    .Dataout(Dataout), .Wr(Wr)
  );

  // Byte-addressed memory: registered read, write on Wr
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++)
      rdWord[8*i +: 8] = simMem.exists(raddress + 64'(i)) ? simMem[raddress + 64'(i)] : 8'h00;
    Dataout <= rdWord;
    if (Wr) begin
      for (int i = 0; i < 4; i++) simMem[waddress + 64'(i)] = Datain[8*i +: 8];
      wrAddrLog.push_back(waddress);
      wrDataLog.push_back(Datain);
    end
    if (resp_valid) respCount++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic poke(input logic [63:0] a, input logic [7:0] b);
    simMem[a] = b;
    refMem[a] = b;
  endtask

  function automatic logic [7:0] refByte(input logic [63:0] a);
    return refMem.exists(a) ? refMem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] refLoad(input logic [63:0] a, input logic [1:0] sz, input logic uns);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refByte(a + 64'(i));
    if (!uns && sz != 2'd3 && v[8*n-1]) v = v | (~64'h0 << (8*n));
    return v;
  endfunction

  task automatic refStore(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) refMem[a + 64'(i)] = wd[8*i +: 8];
  endtask

  // Entered and left at #1 after an edge with the unit idle
  task automatic doReq(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd);
    int lat;
    int expLat;
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    lat = 1;
    ra1 = raddress;
    ra2 = '0;
    while (!resp_valid && lat < 12) begin
      @(posedge Clk); #1;
      lat++;
      if (lat == 2) ra2 = raddress;
    end
    expLat = we ? (sz == 2'd3 ? 3 : sz == 2'd2 ? 2 : 4) : (sz == 2'd3 ? 4 : 3);
    check(we ? "st_latency" : "ld_latency", 64'(lat), 64'(expLat));
    if (we) refStore(a, sz, wd);
    else lastLoad = refLoad(a, sz, uns);
    check(we ? "st_rdata_hold" : "ld_rdata", resp_rdata, lastLoad);
    @(posedge Clk); #1;
    check("resp_pulse_width", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int firstReady;
    int pulses;
    int respSnap;
    logic acc;
    poke(64'h100, 8'h80); poke(64'h101, 8'h7F); poke(64'h102, 8'h01); poke(64'h103, 8'hFF);
    for (int i = 0; i < 8; i++) poke(64'hFFFF_FFFF_FFFF_FFFE + 64'(i), 8'($urandom));
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_raddress", raddress, 64'd0);
    check("rst_waddress", waddress, 64'd0);
    check("rst_datain", 64'(Datain), 64'd0);
    check("rst_wr", 64'(Wr), 64'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    doReq(1'b0, 2'd0, 1'b0, 64'h100, '0);
    check("lb_const", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_raddress", ra1, 64'h100);
    doReq(1'b0, 2'd0, 1'b1, 64'h100, '0);
    check("lbu_const", resp_rdata, 64'h80);
    doReq(1'b0, 2'd1, 1'b0, 64'h100, '0);
    check("lh_const", resp_rdata, 64'h7F80);
    doReq(1'b0, 2'd2, 1'b0, 64'h100, '0);
    check("lw_const", resp_rdata, 64'hFFFF_FFFF_FF01_7F80);
    doReq(1'b0, 2'd2, 1'b1, 64'h100, '0);
    check("lwu_const", resp_rdata, 64'h0000_0000_FF01_7F80);

    wrAddrLog.delete(); wrDataLog.delete();
    doReq(1'b1, 2'd3, 1'b0, 64'h200, 64'h1122_3344_5566_7788);
    check("sd_wr_cycles", 64'(wrAddrLog.size()), 64'd2);
    if (wrAddrLog.size() == 2) begin
      check("sd_waddr_lo", wrAddrLog[0], 64'h200);
      check("sd_waddr_hi", wrAddrLog[1], 64'h204);
      check("sd_data_lo", 64'(wrDataLog[0]), 64'h5566_7788);
      check("sd_data_hi", 64'(wrDataLog[1]), 64'h1122_3344);
    end
    doReq(1'b0, 2'd3, 1'b0, 64'h200, '0);
    check("ld_after_sd", resp_rdata, 64'h1122_3344_5566_7788);

    wrAddrLog.delete(); wrDataLog.delete();
    doReq(1'b1, 2'd0, 1'b0, 64'h100, 64'hAB);
    check("sb_read_first", ra1, 64'h100);
    check("sb_wr_cycles", 64'(wrAddrLog.size()), 64'd1);
    if (wrAddrLog.size() == 1) check("sb_merge", 64'(wrDataLog[0]), 64'hFF01_7FAB);
    doReq(1'b0, 2'd2, 1'b0, 64'h100, '0);
    check("lw_after_sb", resp_rdata, 64'hFFFF_FFFF_FF01_7FAB);

    // Reset asserted mid-cycle during the high-word write of a doubleword store
    for (int i = 0; i < 8; i++) poke(64'h300 + 64'(i), 8'hEE);
    wrAddrLog.delete(); wrDataLog.delete();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'h300;
    req_wdata = 64'hCAFE_F00D_DEAD_BEEF;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    check("rst_sd_wr_lo", 64'(Wr), 64'd1);
    @(posedge Clk); #1;
    check("rst_sd_wr_hi", 64'(Wr), 64'd1);
    check("rst_sd_waddr_hi", waddress, 64'h304);
    respSnap = respCount;
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_wr", 64'(Wr), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_resp", 64'(resp_valid), 64'd0);
    #2 Reset_n = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    check("rst_no_resp", 64'(respCount), 64'(respSnap));
    check("rst_wr_count", 64'(wrAddrLog.size()), 64'd1);
    refStore(64'h300, 2'd2, 64'hDEAD_BEEF);
    lastLoad = '0;
    doReq(1'b0, 2'd3, 1'b0, 64'h300, '0);
    check("rst_sd_lo_only", resp_rdata, 64'hEEEE_EEEE_DEAD_BEEF);

    // Second request held valid while the first is in flight
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 64'h100;
    @(posedge Clk); #1;
    req_size = 2'd1; req_unsigned = 1'b1; req_addr = 64'h102;
    firstReady = 0;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      if (req_ready && firstReady == 0) firstReady = c;
      if (resp_valid) begin
        pulses++;
        if (pulses == 1) check("busy_first", resp_rdata, refLoad(64'h100, 2'd2, 1'b0));
        else check("busy_second", resp_rdata, refLoad(64'h102, 2'd1, 1'b1));
      end
      acc = req_valid && req_ready;
      @(posedge Clk); #1;
      if (acc) req_valid = 1'b0;
    end
    check("busy_accept_cycle", 64'(firstReady), 64'd4);
    check("busy_pulses", 64'(pulses), 64'd2);
    lastLoad = refLoad(64'h102, 2'd1, 1'b1);

    doReq(1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, '0);
    check("wrap_raddr_lo", ra1, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_raddr_hi", ra2, 64'h0000_0000_0000_0002);

    for (int k = 0; k < 40; k++)
      doReq(1'($urandom), 2'($urandom), 1'($urandom), 64'h100 + 64'($urandom_range(0, 40)),
            {$urandom, $urandom});
    for (int a = 'h100; a < 'h130; a += 8) doReq(1'b0, 2'd3, 1'b0, 64'(a), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end
endmodule
